// File: rtl/wb_cmd_master_if.sv
// Classic Wishbone bus bundle shared by wb_cmd_master and the interconnect.
// dat_i carries master-to-slave write data, dat_o carries slave-to-master read data.
interface wb_interface #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     clk;
    logic                     rst;
    logic [ADDRESS_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0]    dat_i;
    logic [DATA_WIDTH-1:0]    dat_o;
    logic                     we;
    logic                     stb;
    logic                     cyc;
    logic                     ack;

    modport master (output clk, rst, adr, dat_i, we, stb, cyc, input dat_o, ack);
    modport slave  (input clk, rst, adr, dat_i, we, stb, cyc, output dat_o, ack);
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone master: valid/ready command in, classic cycle out, response back.
// Optional macro WB_CMD_MASTER_STATS_EN adds saturating stat_txn / stat_timeout counters.
module wb_cmd_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_adr,
    input  logic [DATA_WIDTH-1:0]    req_dat,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_dat,
    output logic                     rsp_err,
`ifdef WB_CMD_MASTER_STATS_EN
    output logic [31:0]              stat_txn,
    output logic [15:0]              stat_timeout,
`endif
    wb_interface.master              m_wb
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    // Handshake rule for both streams: a transfer happens on a rising edge
    // where valid and ready are both 1; valid holds its payload until then.
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                   r_state;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_dat;
    logic                     r_rsp_err;
    logic                     r_cyc;
    logic                     r_stb;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0]    r_dat;
    logic [TW-1:0]            r_timer;
    logic                     w_ack;
    logic                     w_rsp_hs;

    // X or Z on ack compares as not-equal and so never terminates the cycle.
    assign w_ack    = (m_wb.ack == 1'b1);
    assign w_rsp_hs = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_adr       <= req_adr;
                        r_dat       <= req_dat;
                        r_timer     <= '0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_BUS;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_BUS: begin
                    if (w_ack) begin
                        r_rsp_dat   <= r_we ? '0 : m_wb.dat_o;
                        r_rsp_err   <= 1'b0;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_timer == TLAST) begin
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    // req_ready comes back from IDLE one cycle later, no bypass.
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_CMD_MASTER_STATS_EN
    logic [31:0] r_stat_txn;
    logic [15:0] r_stat_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_txn     <= '0;
            r_stat_timeout <= '0;
        end else if (w_rsp_hs) begin
            if (r_stat_txn != '1) begin
                r_stat_txn <= r_stat_txn + 1'b1;
            end
            if (r_rsp_err && (r_stat_timeout != '1)) begin
                r_stat_timeout <= r_stat_timeout + 1'b1;
            end
        end
    end

    assign stat_txn     = r_stat_txn;
    assign stat_timeout = r_stat_timeout;
`endif

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_err    = r_rsp_err;
    assign m_wb.clk   = clk;
    assign m_wb.rst   = ~rst_n;
    assign m_wb.cyc   = r_cyc;
    assign m_wb.stb   = r_stb;
    assign m_wb.we    = r_we;
    assign m_wb.adr   = r_adr;
    assign m_wb.dat_i = r_dat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized scoreboard bench for wb_cmd_master with a behavioural Wishbone slave.
module tb_wb_cmd_master;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
`ifdef WB_CMD_MASTER_STATS_EN
    logic [31:0] stat_txn;
    logic [15:0] stat_timeout;
`endif

    wb_interface #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) wb ();

    wb_cmd_master #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
`ifdef WB_CMD_MASTER_STATS_EN
        .stat_txn(stat_txn), .stat_timeout(stat_timeout),
`endif
        .m_wb(wb)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [64:0] bus_q[$];
    int          len_q[$];
    int          wait_q[$];
    logic [31:0] ref_mem[1024];
    logic [31:0] slv_mem[1024];
    int          exp_txn = 0;
    int          exp_to = 0;
    bit          bp_mode = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: acks after a per-command wait count; huge wait models an unmapped address.
    bit          slv_active = 1'b0;
    int          slv_cnt = 0;
    int          slv_wait = 0;
    int          slv_len = 0;
    logic [64:0] slv_bus = '0;
    initial begin
        wb.ack = 1'b0;
        wb.dat_o = '0;
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            wb.ack = 1'b0;
            slv_active = 1'b0;
        end else if (wb.cyc && wb.stb) begin
            if (!slv_active) begin
                slv_active = 1'b1;
                slv_cnt = 0;
                if (wait_q.size() == 0 || bus_q.size() == 0 || len_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bus_unexpected: got stb=1 required no cycle");
                    slv_wait = 1000; slv_len = -1; slv_bus = 'x;
                end else begin
                    slv_wait = wait_q.pop_front();
                    slv_bus = bus_q.pop_front();
                    slv_len = len_q.pop_front();
                end
            end
            check("bus_attr", {31'd0, wb.we, wb.adr, wb.dat_i}, {31'd0, slv_bus});
            if (slv_cnt == slv_wait) begin
                wb.ack = 1'b1;
                if (wb.we) begin
                    slv_mem[wb.adr[11:2]] = wb.dat_i;
                    wb.dat_o = $urandom;
                end else begin
                    wb.dat_o = slv_mem[wb.adr[11:2]];
                end
            end else begin
                wb.ack = 1'b0;
                wb.dat_o = $urandom;
            end
            slv_cnt++;
        end else begin
            wb.ack = 1'b0;
            if (slv_active) begin
                check("stb_len", 96'(slv_cnt), 96'(slv_len));
                slv_active = 1'b0;
            end
        end
    end

    // Response monitor: pops the expected queue on every response handshake.
    bit          held = 1'b0;
    logic [32:0] held_val = '0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            check("req_ready_in_resp", 96'(req_ready), 96'(0));
            if (held) check("rsp_stable", 96'({rsp_err, rsp_dat}), 96'(held_val));
            if (rsp_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: got %0h required none", {rsp_err, rsp_dat});
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", 96'({rsp_err, rsp_dat}), 96'(e));
                    exp_txn++;
                    if (e[32]) exp_to++;
                end
            end else begin
                held = 1'b1;
                held_val = {rsp_err, rsp_dat};
            end
        end else begin
            held = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1 rsp_ready = bp_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Reference model: a read returns the last write that was acked; w >= TO never acks.
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input int w);
        bit          err;
        bit          got;
        logic [31:0] rd;
        err = (w >= TO);
        rd = (!err && !we) ? ref_mem[adr[11:2]] : 32'd0;
        req_valid = 1'b1;
        req_we = we;
        req_adr = adr;
        req_dat = dat;
        got = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: got req_ready=0 required 1 within 300 cycles");
            req_valid = 1'b0;
            return;
        end
        if (!err && we) ref_mem[adr[11:2]] = dat;
        exp_q.push_back({err, rd});
        bus_q.push_back({we, adr, dat});
        len_q.push_back(err ? TO : w + 1);
        wait_q.push_back(err ? 1000 : w);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_adr = $urandom;
        req_dat = $urandom;
    endtask

    task automatic drain();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid && !wb.stb) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    endtask

    task automatic check_stats();
`ifdef WB_CMD_MASTER_STATS_EN
        check("stat_txn", 96'(stat_txn), 96'(exp_txn));
        check("stat_timeout", 96'(stat_timeout), 96'(exp_to));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        ref_mem[32'h10 >> 2] = 32'h1234_5678;
        slv_mem[32'h10 >> 2] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 96'(req_ready), 96'(0));
        check("rst_rsp", 96'({rsp_valid, rsp_err, rsp_dat}), 96'(0));
        check("rst_bus_ctl", 96'({wb.cyc, wb.stb, wb.we}), 96'(0));
        check("rst_bus_data", 96'({wb.adr, wb.dat_i}), 96'(0));
        check("rst_wb_rst", 96'(wb.rst), 96'(1));
        check_stats();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("req_ready_after_reset", 96'(req_ready), 96'(1));

        send_cmd(1'b1, 32'h400, 32'hDEAD_BEEF, 0);
        send_cmd(1'b0, 32'h10, 32'h0, 3);
        send_cmd(1'b0, 32'h800, 32'h0, 100);
        send_cmd(1'b0, 32'h400, 32'h0, TO - 1);
        drain();

        bp_mode = 1'b1;
        send_cmd(1'b0, 32'h10, 32'h0, 0);
        fork
            begin
                repeat (12) @(posedge clk);
                bp_mode = 1'b0;
            end
            send_cmd(1'b1, 32'h20, 32'hA5A5_0F0F, 1);
        join
        drain();

        for (int i = 0; i < 40; i++) begin
            send_cmd(1'($urandom), 32'($urandom_range(0, 1023)) << 2, $urandom,
                     int'($urandom_range(0, TO + 3)));
        end
        drain();
        check_stats();

        send_cmd(1'b0, 32'h20, 32'h0, 100);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc_stb", 96'({wb.cyc, wb.stb}), 96'(0));
        check("async_rst_rsp_valid", 96'(rsp_valid), 96'(0));
        exp_q.delete();
        bus_q.delete();
        len_q.delete();
        wait_q.delete();
        exp_txn = 0;
        exp_to = 0;
        check_stats();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_req_ready_low", 96'(req_ready), 96'(0));
        @(posedge clk);
        #1;
        check("post_rst_req_ready", 96'(req_ready), 96'(1));
        check("post_rst_no_stale_rsp", 96'(rsp_valid), 96'(0));
        send_cmd(1'b0, 32'h400, 32'h0, 2);
        drain();
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
